// File: rtl/hybrid_pkg.sv
// Shared types and widths for the hybrid immediate encoder.
// Long constants are split into HI/LO words around SPLIT_SHIFT.
package hybrid_pkg;

    localparam int IMM_W       = 27;
    localparam int IMM_SHORT_W = 14;
    localparam int SPLIT_SHIFT = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational range check.
// Decides whether a 32-bit constant fits the 14-bit or the 27-bit immediate form.
module imm_fit_check
    import hybrid_pkg::*;
(
    input  logic [31:0] value,
    input  logic        is_signed,
    output logic        fits14,
    output logic        fits27
);

    // Bits below the 14-bit window never affect whether a value fits.
    logic unused_low;
    assign unused_low = ^value[12:0];

    // Signed forms require the dropped upper bits to replicate the sign bit.
    // Unsigned forms require those bits to be zero.
    always_comb begin
        fits14 = 1'b0;
        fits27 = 1'b0;
        if (is_signed) begin
            fits14 = (&value[31:13]) | ~(|value[31:13]);
            fits27 = (&value[31:26]) | ~(|value[31:26]);
        end else begin
            fits14 = ~(|value[31:14]);
            fits27 = ~(|value[31:27]);
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Streams 32-bit constants out as one or two immediate words (14-bit, 27-bit, or HI/LO split).
// Each word also carries the extender controls for that word.
module imm_encoder
    import hybrid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_immsrc,
    output logic             out_immext,
    output logic             out_split,
    output logic             out_last,
    output logic [7:0]       split_count
);

    state_t                 state;
    logic [IMM_SHORT_W-1:0] lo_bits;
    logic                   fits14;
    logic                   fits27;
    logic                   accept;

    imm_fit_check u_fit (
        .value     (in_value),
        .is_signed (in_signed),
        .fits14    (fits14),
        .fits27    (fits27)
    );

    assign in_ready  = (state == IDLE) | (((state == ONE) | (state == LO)) & out_ready);
    assign out_valid = (state != IDLE);
    assign accept    = in_valid & in_ready;

    // The HI word must drain before new input is taken.
    // lo_bits is captured at accept so the LO word does not depend on later in_value changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lo_bits     <= '0;
            out_imm     <= '0;
            out_immsrc  <= 1'b0;
            out_immext  <= 1'b0;
            out_split   <= 1'b0;
            out_last    <= 1'b0;
            split_count <= 8'd0;
        end else if (state == HI) begin
            if (out_ready) begin
                state      <= LO;
                out_imm    <= {13'b0, lo_bits};
                out_immsrc <= 1'b0;
                out_immext <= 1'b0;
                out_split  <= 1'b1;
                out_last   <= 1'b1;
            end
        end else if (accept) begin
            if (fits14) begin
                state      <= ONE;
                out_imm    <= {13'b0, in_value[IMM_SHORT_W-1:0]};
                out_immsrc <= 1'b0;
                out_immext <= in_signed;
                out_split  <= 1'b0;
                out_last   <= 1'b1;
            end else if (fits27) begin
                state      <= ONE;
                out_imm    <= in_value[IMM_W-1:0];
                out_immsrc <= 1'b1;
                out_immext <= in_signed;
                out_split  <= 1'b0;
                out_last   <= 1'b1;
            end else begin
                state      <= HI;
                lo_bits    <= in_value[IMM_SHORT_W-1:0];
                out_imm    <= {9'b0, in_value[31:SPLIT_SHIFT]};
                out_immsrc <= 1'b1;
                out_immext <= 1'b0;
                out_split  <= 1'b1;
                out_last   <= 1'b0;
                if (split_count != 8'hFF) begin
                    split_count <= split_count + 8'd1;
                end
            end
        end else if ((state != IDLE) && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder.
// Expected words are hand-computed and checked with immediate assertions.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] out_imm;
    logic        out_immsrc;
    logic        out_immext;
    logic        out_split;
    logic        out_last;
    logic [7:0]  split_count;

    int vectors = 0;
    int miscompares = 0;

    imm_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_immsrc  (out_immsrc),
        .out_immext  (out_immext),
        .out_split   (out_split),
        .out_last    (out_last),
        .split_count (split_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] value, input logic sgn);
        in_valid  = valid;
        in_value  = value;
        in_signed = sgn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
            $error("[TB] miscompare on %s", tag);
        end
    endtask

    task automatic checkWord(input string tag, input logic [26:0] imm, input logic immsrc,
                             input logic immext, input logic split, input logic last);
        checkOutput({tag, ".valid"},  {31'd0, out_valid},  32'd1);
        checkOutput({tag, ".imm"},    {5'd0, out_imm},     {5'd0, imm});
        checkOutput({tag, ".immsrc"}, {31'd0, out_immsrc}, {31'd0, immsrc});
        checkOutput({tag, ".immext"}, {31'd0, out_immext}, {31'd0, immext});
        checkOutput({tag, ".split"},  {31'd0, out_split},  {31'd0, split});
        checkOutput({tag, ".last"},   {31'd0, out_last},   {31'd0, last});
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        #2;
        checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.imm",   {5'd0, out_imm},    32'd0);
        checkOutput("rst.count", {24'd0, split_count}, 32'd0);
        step();
        step();
        rst = 1'b0;
        checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // 14-bit signed boundaries, back to back
        applyStimulus(1'b1, 32'h0000_1FFF, 1'b1);
        step();
        checkWord("s14pos", 27'h0001FFF, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("s14pos.in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'hFFFF_E000, 1'b1);
        step();
        checkWord("s14neg", 27'h0002000, 1'b0, 1'b1, 1'b0, 1'b1);

        // 27-bit forms
        applyStimulus(1'b1, 32'h0000_2000, 1'b1);
        step();
        checkWord("s27", 27'h0002000, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h07FF_FFFF, 1'b0);
        step();
        checkWord("u27max", 27'h7FFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_3FFF, 1'b0);
        step();
        checkWord("u14max", 27'h0003FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_4000, 1'b0);
        step();
        checkWord("u14over", 27'h0004000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFC00_0000, 1'b1);
        step();
        checkWord("s27neg", 27'h4000000, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checkOutput("idle.valid", {31'd0, out_valid}, 32'd0);

        // Split with in_value changing after accept
        applyStimulus(1'b1, 32'h1234_5678, 1'b0);
        step();
        checkWord("split1.hi", 27'h00048D1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("split1.hi.in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1);
        step();
        checkWord("split1.lo", 27'h0001678, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("split1.count", {24'd0, split_count}, 32'd1);
        step();

        // Backpressure while in HI; the offered input must be ignored
        applyStimulus(1'b1, 32'hABCD_E123, 1'b0);
        step();
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h5555_5555, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkWord("hold.hi", 27'h002AF37, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("hold.in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checkWord("hold.lo", 27'h0002123, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("hold.count", {24'd0, split_count}, 32'd2);

        // Asynchronous reset while the LO word is pending
        rst = 1'b1;
        #1;
        checkOutput("rstlo.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstlo.count", {24'd0, split_count}, 32'd0);
        checkOutput("rstlo.imm",   {5'd0, out_imm},    32'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        checkWord("post.rst", 27'h0003FFF, 1'b0, 1'b1, 1'b0, 1'b1);

        // ONE followed directly by a split accepted in the same cycle
        applyStimulus(1'b1, 32'h8000_0000, 1'b0);
        step();
        checkWord("b2b.hi", 27'h0020000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checkWord("b2b.lo", 27'h0000000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("b2b.count", {24'd0, split_count}, 32'd1);
        step();

        // Saturation: 299 more splits on top of the one above, two cycles each
        applyStimulus(1'b1, 32'hF800_0000, 1'b1);
        for (int i = 0; i < 598; i++) begin
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checkOutput("sat.count", {24'd0, split_count}, 32'd255);
        checkOutput("sat.last", {31'd0, out_last}, 32'd1);
        step();
        checkOutput("sat.idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- in_valid, in, 1: in_value/in_signed are valid.
- in_ready, out, 1: encoder accepts input this cycle.
- in_value, in, 32: full-width constant to encode.
- in_signed, in, 1: 1 = signed (sign-extended) encoding, 0 = unsigned (zero-extended).
- out_valid, out, 1: output field valid.
- out_ready, in, 1: consumer accepts output this cycle.
- out_imm, out, 27: immediate field; 14-bit forms occupy [13:0], with [26:14] = 0.
- out_immsrc, out, 1: 0 = 14-bit form, 1 = 27-bit form (extender ImmSrc).
- out_immext, out, 1: 1 = sign-extend, 0 = zero-extend (extender ImmExt).
- out_split, out, 1: word belongs to a two-word (HI/LO) sequence.
- out_last, out, 1: final word of the current constant.
- split_count, out, 8: saturating count of constants that needed splitting.

Function
REQ-002 Fit check for signed input SHALL be: fits14 iff in_value[31:13] all equal; fits27 iff in_value[31:26] all equal.
REQ-003 Fit check for unsigned input SHALL be: fits14 iff in_value[31:14] == 0; fits27 iff in_value[31:27] == 0.
REQ-004 A fits14 input SHALL emit one word with these fields:
- out_imm = {13'b0, in_value[13:0]}
- out_immsrc = 0, out_immext = in_signed
- out_last = 1, out_split = 0
REQ-005 A fits27 input that is not fits14 SHALL emit one word: out_imm = in_value[26:0], out_immsrc = 1, out_immext = in_signed, out_last = 1, out_split = 0.
REQ-006 Any other input SHALL emit two words, split = 1 on both, with in_signed ignored:
- HI word: out_imm = {9'b0, in_value[31:14]}, immsrc = 1, immext = 0, last = 0.
- LO word: out_imm = {13'b0, in_value[13:0]}, immsrc = 0, immext = 0, last = 1.
REQ-007 The FSM SHALL have states IDLE, ONE, HI and LO. Transitions:
- IDLE: accept to ONE (single-word input) or to HI (split input).
- HI: to LO on out_ready.
- ONE or LO: on out_ready, go to IDLE, or to ONE/HI if a new input is accepted the same cycle.
REQ-008 in_ready SHALL equal (state == IDLE) OR (state is ONE or LO AND out_ready); it SHALL be 0 in HI.
REQ-009 out_valid SHALL be 1 exactly when state != IDLE.
REQ-010 Output fields SHALL be registered, with latency 1 cycle from accepting handshake to out_valid.
REQ-011 Output fields SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-012 Back-to-back single-word inputs SHALL sustain one word per cycle when out_ready is held at 1.
REQ-013 The lower 14 bits of a split input SHALL be captured at accept, so the LO word is independent of later in_value changes.
REQ-014 split_count SHALL increment on accept of a split input and saturate at 255.
REQ-015 in_value SHALL be ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-016 Asserting rst SHALL asynchronously set the following, and discard any pending LO word:
- state = IDLE
- out_valid = 0, out_imm = 0, out_immsrc = 0, out_immext = 0, out_split = 0, out_last = 0
- split_count = 0
REQ-017 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-018 The package hybrid_pkg SHALL hold:
- the state enum (IDLE, ONE, HI, LO)
- the widths IMM_W = 27, IMM_SHORT_W = 14, SPLIT_SHIFT = 14
REQ-019 The fit check SHALL be a combinational sub-module imm_fit_check with inputs value and signed and outputs fits14 and fits27; the FSM stays in imm_encoder.

Verification
REQ-020 Scenario: signed 0x00001FFF, then signed 0xFFFFE000 -> two words, imm = 0x1FFF then 0x2000, immsrc = 0, immext = 1, last = 1.
REQ-021 Scenario: signed 0x00002000 -> imm = 0x0002000, immsrc = 1, immext = 1; unsigned 0x07FFFFFF -> imm = 0x7FFFFFF, immsrc = 1, immext = 0.
REQ-022 Scenario: unsigned 0x12345678 -> HI imm = 0x48D1 (immsrc = 1, last = 0), then LO imm = 0x1678 (immsrc = 0, last = 1); split_count = 1.
REQ-023 Scenario: out_ready = 0 for 3 cycles while in HI -> HI word held stable, in_ready = 0; releasing out_ready gives LO on the next cycle.
REQ-024 Scenario: rst pulsed while in LO -> out_valid = 0 immediately, split_count = 0, and the next input is encoded correctly.
REQ-025 Scenario: 300 split inputs -> split_count saturates at 255.
